instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory interface. Owns the PC, drives
//  the word address into the combinational instruction memory, and captures
//  the returned word into the IF/ID pipeline register.
//  Handles stall, decode/execute redirect (branch taken) and early J-type
//  resolution. Sits between the instruction ROM and the decode stage.
// PARAMETERS
//  RESET_PC    0            PC loaded on reset (word index)
//  LAST_ADDR   100          highest valid memory word index
//  JUMP_OPCODE 6'b100000    opcode (instr[31:26]) resolved early in fetch
//  EARLY_JUMP  1            1: resolve J-type in fetch; 0: sequential only
// PORTS
//  clk               input   1   rising-edge clock
//  reset             input   1   asynchronous, active-high reset
//  imem_address      output  32  word index to instruction memory (= pc)
//  imem_instruction  input   32  instruction word, valid same cycle as address
//  stall             input   1   hold PC and IF/ID register
//  redirect_valid    input   1   taken branch / redirect from later stage
//  redirect_target   input   32  new PC (word index) when redirect_valid
//  if_id_instruction output  32  captured instruction (32'b0 = NOP)
//  if_id_pc          output  32  PC of captured instruction
//  if_id_pc_plus1    output  32  if_id_pc + 1
//  if_id_valid       output  1   IF/ID holds a real instruction
//  halted            output  1   fetch stopped past LAST_ADDR
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation): pc=RESET_PC, state=IDLE,
//   if_id_instruction=0, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0, halted=0.
//  imem_address = pc, combinational from the PC register; memory answers in
//   the same cycle, so fetch latency is 1 clock (address -> IF/ID).
//  States: IDLE, FETCH, HALTED.
//  - IDLE: first edge after reset release -> FETCH; no capture, valid stays 0.
//  - FETCH, per edge, priority redirect > stall > jump > sequential:
//    redirect_valid: pc<=redirect_target; IF/ID flushed (instr=0, valid=0),
//     even if stall=1. Target > LAST_ADDR -> HALTED.
//    stall (no redirect): pc and all IF/ID outputs hold.
//    otherwise capture: if_id_instruction<=imem_instruction, if_id_pc<=pc,
//     if_id_pc_plus1<=pc+1, if_id_valid<=1. Next pc:
//     EARLY_JUMP && instr[31:26]==JUMP_OPCODE -> {pc[31:26],instr[25:0]}
//     (no bubble; jump word itself still passed to decode), else pc+1.
//     Next pc > LAST_ADDR -> HALTED (the instruction at LAST_ADDR or the
//     jump is still captured valid).
//  - HALTED: halted=1; pc holds. First non-stalled edge clears if_id_valid
//    and zeroes if_id_instruction; stall holds IF/ID. redirect_valid with
//    target <= LAST_ADDR -> FETCH, pc<=target, halted<=0, IF/ID flushed.
//  Arithmetic: pc+1 unsigned 32-bit; no wrap possible since HALTED is
//   entered before pc exceeds LAST_ADDR.
//  halted asserts on the edge that enters HALTED, registered.
// TESTING
//  1 Reset, release, mock ROM returns ADD words at 0,1,2 -> IF/ID pc 0,1,2 on
//    consecutive edges after IDLE, valid=1, instructions match ROM.
//  2 ROM[7]=32'b100000_..._01001 -> after pc 7 captured, next pc=9 (no 8),
//    if_id_pc sequence 7,9, valid never drops.
//  3 pc=4, redirect_valid=1 target=5 with stall=1 same cycle -> pc=5,
//    if_id_valid=0, if_id_instruction=0; next edge captures pc 5.
//  4 stall held 3 cycles at pc=6 -> imem_address=6, IF/ID unchanged 3 cycles.
//  5 LAST_ADDR=10, run sequentially -> pc 10 captured valid, halted=1 next,
//    valid drops one edge later; redirect to 3 -> resumes, halted=0.
//  6 Assert reset mid-stream at pc=5 between edges -> outputs at reset
//    values immediately; after release IDLE then fetch from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Bus between the fetch unit, the instruction ROM, the later pipeline stages and decode.
// The fetch unit is the master; the environment side (ROM, hazard logic, decode) is the slave.
interface instruction_fetch_unit_if;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic        halted;

  modport master (
    output imem_address, if_id_instruction, if_id_pc, if_id_pc_plus1, if_id_valid, halted,
    input  imem_instruction, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_address, if_id_instruction, if_id_pc, if_id_pc_plus1, if_id_valid, halted,
    output imem_instruction, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction ROM and fills the IF/ID register.
// Handles stall, redirects from later stages, early J-type resolution and halting past the last word.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned LAST_ADDR   = 100,
  parameter logic [5:0]  JUMP_OPCODE = 6'b100000,
  parameter bit          EARLY_JUMP  = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  instruction_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  localparam logic [31:0] LAST_WORD = 32'(LAST_ADDR);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc1_q, if_pc1_d;
  logic        valid_q, valid_d;

  logic        jump_hit;
  logic [31:0] next_fetch_pc;

  assign jump_hit      = EARLY_JUMP && (bus.imem_instruction[31:26] == JUMP_OPCODE);
  assign next_fetch_pc = jump_hit ? {pc_q[31:26], bus.imem_instruction[25:0]} : pc_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    if_pc_d  = if_pc_q;
    if_pc1_d = if_pc1_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_target;
          instr_d = 32'd0;
          valid_d = 1'b0;
          if (bus.redirect_target > LAST_WORD) state_d = HALTED;
        end else if (!bus.stall) begin
          instr_d  = bus.imem_instruction;
          if_pc_d  = pc_q;
          if_pc1_d = pc_q + 32'd1;
          valid_d  = 1'b1;
          // Running off the end keeps the PC on the last fetched word.
          if (next_fetch_pc > LAST_WORD) state_d = HALTED;
          else                           pc_d    = next_fetch_pc;
        end
      end
      HALTED: begin
        if (bus.redirect_valid && (bus.redirect_target <= LAST_WORD)) begin
          pc_d    = bus.redirect_target;
          instr_d = 32'd0;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!bus.stall) begin
          instr_d = 32'd0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      if_pc_q  <= 32'd0;
      if_pc1_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      if_pc1_q <= if_pc1_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.imem_address      = pc_q;
  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_pc          = if_pc_q;
  assign bus.if_id_pc_plus1    = if_pc1_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.halted            = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of the fetch unit against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam int          LAST   = 10;
  localparam logic [5:0]  JOP    = 6'b100000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC    (32'd0),
    .LAST_ADDR   (LAST),
    .JUMP_OPCODE (JOP),
    .EARLY_JUMP  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [0:31];
  assign bus.imem_instruction = (bus.imem_address < 32) ? rom[bus.imem_address[4:0]] : 32'd0;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: mode 0 = waiting after reset, 1 = fetching, 2 = halted
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc1;
  logic        m_valid;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a < 32) ? rom[a[4:0]] : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc1 = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    logic [31:0] word, nxt;
    word = rom_word(m_pc);
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_target; m_instr = 0; m_valid = 0;
        if (bus.redirect_target > LAST) m_mode = 2;
      end else if (!bus.stall) begin
        m_instr = word; m_ifpc = m_pc; m_ifpc1 = m_pc + 1; m_valid = 1;
        nxt = (word[31:26] == JOP) ? {m_pc[31:26], word[25:0]} : m_pc + 1;
        if (nxt > LAST) m_mode = 2;
        else            m_pc = nxt;
      end
    end else begin
      if (bus.redirect_valid && bus.redirect_target <= LAST) begin
        m_pc = bus.redirect_target; m_instr = 0; m_valid = 0; m_mode = 1;
      end else if (!bus.stall) begin
        m_instr = 0; m_valid = 0;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".addr"},  bus.imem_address, m_pc);
    chk({ctx, ".instr"}, bus.if_id_instruction, m_instr);
    chk({ctx, ".ifpc"},  bus.if_id_pc, m_ifpc);
    chk({ctx, ".ifpc1"}, bus.if_id_pc_plus1, m_ifpc1);
    chk({ctx, ".valid"}, 32'(bus.if_id_valid), 32'(m_valid));
    chk({ctx, ".halted"}, 32'(bus.halted), 32'(m_mode == 2));
  endtask

  task automatic tick(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
    $display("edge t=%0t stall=%0b redir=%0b tgt=%0d -> pc=%0d if_pc=%0d valid=%0b halted=%0b",
             $time, bus.stall, bus.redirect_valid, bus.redirect_target,
             bus.imem_address, bus.if_id_pc, bus.if_id_valid, bus.halted);
  endtask

  task automatic run_to(input logic [31:0] t);
    for (int g = 0; g < 40 && m_pc != t; g++) tick("run");
    chk("reach_pc", bus.imem_address, t);
  endtask

  task automatic redirect(input logic [31:0] t, input logic st);
    bus.redirect_valid = 1'b1; bus.redirect_target = t; bus.stall = st;
    tick("redirect");
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'd0; bus.stall = 1'b0;
  endtask

  task automatic check_reset_values(input string ctx);
    chk({ctx, ".addr"},   bus.imem_address, 32'd0);
    chk({ctx, ".instr"},  bus.if_id_instruction, 32'd0);
    chk({ctx, ".ifpc"},   bus.if_id_pc, 32'd0);
    chk({ctx, ".ifpc1"},  bus.if_id_pc_plus1, 32'd0);
    chk({ctx, ".valid"},  32'(bus.if_id_valid), 32'd0);
    chk({ctx, ".halted"}, 32'(bus.halted), 32'd0);
  endtask

  initial begin
    logic [31:0] snap_pc, snap_instr;
    for (int i = 0; i < 32; i++) rom[i] = {6'b000000, 5'(i), 5'd2, 5'd3, 11'h020};
    rom[7] = {JOP, 26'd9};
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'd0;
    reset = 1'b1;
    model_reset();
    #12;
    check_reset_values("reset");
    reset = 1'b0;

    // IDLE edge, then sequential fetch from 0
    tick("idle");
    chk("idle_valid", 32'(bus.if_id_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick("seq");
      chk("seq_pc", bus.if_id_pc, 32'(k));
      chk("seq_instr", bus.if_id_instruction, rom[k]);
    end

    // Early jump at 7 skips 8
    run_to(7);
    tick("jump");
    chk("jump_ifpc", bus.if_id_pc, 32'd7);
    chk("jump_next", bus.imem_address, 32'd9);
    tick("after_jump");
    chk("after_jump_ifpc", bus.if_id_pc, 32'd9);
    chk("after_jump_valid", 32'(bus.if_id_valid), 32'd1);

    // Run off LAST: 10 captured valid while halting
    tick("last");
    chk("last_ifpc", bus.if_id_pc, 32'd10);
    chk("last_valid", 32'(bus.if_id_valid), 32'd1);
    chk("last_halted", 32'(bus.halted), 32'd1);
    tick("halted");
    chk("halted_valid", 32'(bus.if_id_valid), 32'd0);
    chk("halted_instr", bus.if_id_instruction, 32'd0);
    redirect(32'd3, 1'b0);
    chk("resume_halted", 32'(bus.halted), 32'd0);
    chk("resume_pc", bus.imem_address, 32'd3);

    // Redirect wins over stall
    run_to(4);
    redirect(32'd5, 1'b1);
    chk("redir_pc", bus.imem_address, 32'd5);
    chk("redir_valid", 32'(bus.if_id_valid), 32'd0);
    chk("redir_instr", bus.if_id_instruction, 32'd0);
    tick("post_redir");
    chk("post_redir_ifpc", bus.if_id_pc, 32'd5);

    // Stall holds for three edges at pc 6
    snap_pc = bus.if_id_pc; snap_instr = bus.if_id_instruction;
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick("stall");
      chk("stall_addr", bus.imem_address, 32'd6);
      chk("stall_ifpc", bus.if_id_pc, snap_pc);
      chk("stall_instr", bus.if_id_instruction, snap_instr);
    end
    bus.stall = 1'b0;

    // Asynchronous reset between edges
    redirect(32'd5, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b0;
    tick("reidle");
    tick("refetch");
    chk("refetch_ifpc", bus.if_id_pc, 32'd0);

    // Randomized phase with random jumps, stalls and redirects
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 4) == 0) rom[i] = {JOP, 26'($urandom_range(0, 13))};
      else rom[i] = {6'($urandom_range(0, 31)), 26'($urandom)};
    end
    for (int n = 0; n < 300; n++) begin
      bus.stall          = ($urandom_range(0, 3) == 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_target = 32'($urandom_range(0, 12));
      tick("rand");
    end
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
